// File: rtl/seq_detect_param_if.sv
// Serial pattern-detector bus: sampled data, runtime configuration strobes and match outputs.
interface seq_detect_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
);
  logic               data_valid;
  logic               data;
  logic               overlap_en;
  logic               pat_load;
  logic [MAX_LEN-1:0] pat_val;
  logic [LEN_W-1:0]   pat_len;
  logic               cnt_clr;
  logic               flag;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output data_valid, data, overlap_en, pat_load, pat_val, pat_len, cnt_clr,
    input  flag, match_cnt
  );

  modport slave (
    input  data_valid, data, overlap_en, pat_load, pat_val, pat_len, cnt_clr,
    output flag, match_cnt
  );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial bit-pattern detector with overlap/non-overlap modes
// and a saturating match counter; state is just history, fill level and pattern.
module seq_detect_param #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0000_1011),
  parameter int                 DEF_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  seq_detect_param_if.slave   bus
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               flag_q, flag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic               enough_bits;
  logic               match;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc_fill(input logic [LEN_W-1:0] v);
    return (v >= MAX_LEN_L) ? MAX_LEN_L : v + LEN_W'(1);
  endfunction

  // The incoming bit completes the candidate window on the same edge it is sampled.
  always_comb begin
    cand = {hist_q[MAX_LEN-2:0], bus.data};
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    enough_bits = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q};
    match = bus.data_valid && !bus.pat_load && (len_q != '0) && enough_bits &&
            (((cand ^ pat_q) & mask) == '0);
  end

  always_comb begin
    hist_d = hist_q;
    pat_d  = pat_q;
    len_d  = len_q;
    fill_d = fill_q;
    flag_d = 1'b0;
    if (bus.pat_load) begin
      // A load discards any bit sampled alongside it; history survives, fill restarts.
      pat_d  = bus.pat_val;
      len_d  = (bus.pat_len > MAX_LEN_L) ? MAX_LEN_L : bus.pat_len;
      fill_d = '0;
    end else if (bus.data_valid) begin
      hist_d = cand;
      fill_d = (match && !bus.overlap_en) ? '0 : sat_inc_fill(fill_q);
      flag_d = match;
    end
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (match) begin
      cnt_d = sat_inc_cnt(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      pat_q  <= DEF_PAT;
      len_q  <= LEN_W'(DEF_LEN);
      fill_q <= '0;
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      fill_q <= fill_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.flag      = flag_q;
  assign bus.match_cnt = cnt_q;

endmodule
